// File: rtl/clk_switch_ctrl.sv
// Clock-switch sequencer for a glitch-free clock mux.
// Moves the mux select to a new clock, then waits for the old clock's gate
// to close and the new clock's gate to open. Each phase has a timeout.
//
// state  | meaning
// STABLE | idle; select and cur_sel reflect the last settled request
// DROP   | select moved; waiting for the old clock's gate to close
// RAISE  | old gate closed; waiting for the new clock's gate to open
module clk_switch_ctrl #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT_SEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  input  logic sw_target,
  input  logic en0_async,
  input  logic en1_async,
  output logic select,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_DROP   = 2'd1,
    ST_RAISE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   en0_s, en1_s;
  logic                   old_en, new_en;

  state_t          state_q, state_d;
  logic            select_q, select_d;
  logic            cur_sel_q, cur_sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;

  // Bring the mux gate-enable status into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], en0_async};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], en1_async};
    end
  end

  assign en0_s     = sync0_q[SYNC_STAGES-1];
  assign en1_s     = sync1_q[SYNC_STAGES-1];
  assign old_en    = cur_sel_q ? en1_s : en0_s;
  assign new_en    = select_q  ? en1_s : en0_s;
  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      select_q  <= INIT_SEL;
      cur_sel_q <= INIT_SEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic; a phase's exit condition takes priority over its timeout.
  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    cur_sel_d = cur_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    timer_d   = timer_q;
    case (state_q)
      ST_STABLE: begin
        if (sw_req) begin
          err_d = 1'b0;
          if (sw_target != cur_sel_q) begin
            select_d = sw_target;
            busy_d   = 1'b1;
            timer_d  = '0;
            state_d  = ST_DROP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!old_en) begin
          timer_d = '0;
          state_d = ST_RAISE;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_STABLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_RAISE: begin
        if (new_en) begin
          cur_sel_d = select_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_STABLE;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_STABLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign select  = select_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed vector table, hand-written corner
// sequences, and a randomized run against a behavioural model.
module tb_clk_switch_ctrl;

  localparam int M_TO = 8;
  localparam int M_SS = 2;

  logic clk = 1'b0;
  logic rst, sw_req, sw_target, en0_async, en1_async;
  logic select, cur_sel, busy, done, err;
  logic [4:0] outv;

  int checks = 0;
  int failures = 0;

  clk_switch_ctrl #(.TIMEOUT(M_TO), .SYNC_STAGES(M_SS), .INIT_SEL(1'b0)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_target(sw_target),
    .en0_async(en0_async), .en1_async(en1_async),
    .select(select), .cur_sel(cur_sel), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign outv = {select, cur_sel, busy, done, err};

  // Behavioural reference: phase 0 idle, 1 waiting old gate off, 2 waiting
  // new gate on. Synchronized status is the async input M_SS edges ago.
  int m_phase = 0;
  int m_cnt = 0;
  bit m_sel = 0, m_cur = 0, m_busy = 0, m_done = 0, m_err = 0;
  bit [M_SS-1:0] h0 = '0, h1 = '0;
  logic [4:0] m_outv;
  assign m_outv = {m_sel, m_cur, m_busy, m_done, m_err};

  always @(posedge clk) begin
    bit s0, s1, oe, ne;
    s0 = h0[M_SS-1];
    s1 = h1[M_SS-1];
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_sel = 0; m_cur = 0;
      m_busy = 0; m_done = 0; m_err = 0; h0 = '0; h1 = '0;
    end else begin
      oe = m_cur ? s1 : s0;
      ne = m_sel ? s1 : s0;
      m_done = 0;
      if (m_phase == 0) begin
        if (sw_req) begin
          m_err = 0;
          if (sw_target != m_cur) begin
            m_sel = sw_target; m_busy = 1; m_cnt = 0; m_phase = 1;
          end else m_done = 1;
        end
      end else begin
        if ((m_phase == 1 && !oe) || (m_phase == 2 && ne)) begin
          if (m_phase == 2) begin
            m_cur = m_sel; m_busy = 0; m_done = 1; m_phase = 0;
          end else begin
            m_phase = 2; m_cnt = 0;
          end
        end else if (m_cnt >= M_TO) begin
          m_err = 1; m_busy = 0; m_phase = 0;
        end else m_cnt = m_cnt + 1;
      end
      h0 = {h0[M_SS-2:0], en0_async};
      h1 = {h1[M_SS-2:0], en1_async};
    end
  end

  typedef struct {
    logic       rst, req, tgt, e0, e1;
    logic [4:0] exp;  // {select, cur_sel, busy, done, err} after the edge
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; sw_req = 0; sw_target = 0; en0_async = 1; en1_async = 0;
    cyc();
    rst = 0;
    repeat (3) cyc();
  endtask

  function automatic vec_t mk(logic r, logic q, logic t, logic a, logic b, logic [4:0] x);
    vec_t v;
    v.rst = r; v.req = q; v.tgt = t; v.e0 = a; v.e1 = b; v.exp = x;
    return v;
  endfunction

  initial begin
    int dcount;
    bit got;
    rst = 1; sw_req = 0; sw_target = 0; en0_async = 1; en1_async = 0;

    tbl[0]  = mk(1, 0, 0, 1, 0, 5'b00000);
    tbl[1]  = mk(0, 1, 0, 1, 0, 5'b00010);
    tbl[2]  = mk(0, 0, 0, 1, 0, 5'b00000);
    tbl[3]  = mk(0, 1, 1, 1, 0, 5'b10100);
    tbl[4]  = mk(0, 0, 0, 1, 0, 5'b10100);
    tbl[5]  = mk(0, 0, 0, 0, 0, 5'b10100);
    tbl[6]  = mk(0, 0, 0, 0, 0, 5'b10100);
    tbl[7]  = mk(0, 0, 0, 0, 0, 5'b10100);
    tbl[8]  = mk(0, 0, 0, 0, 1, 5'b10100);
    tbl[9]  = mk(0, 0, 0, 0, 1, 5'b10100);
    tbl[10] = mk(0, 0, 0, 0, 1, 5'b11010);
    tbl[11] = mk(0, 1, 1, 0, 1, 5'b11010);
    tbl[12] = mk(0, 0, 0, 0, 1, 5'b11000);

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; sw_req = tbl[i].req; sw_target = tbl[i].tgt;
      en0_async = tbl[i].e0; en1_async = tbl[i].e1;
      cyc();
      check($sformatf("tbl_row%0d", i), outv, tbl[i].exp);
    end

    // Timeout in DROP with old gate stuck on.
    do_reset();
    sw_req = 1; sw_target = 1;
    cyc();
    sw_req = 0;
    check("to_start", outv, 5'b10100);
    dcount = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      dcount += int'(done);
    end
    check("to_before", outv, 5'b10100);
    cyc();
    dcount += int'(done);
    check("to_err", outv, 5'b10001);
    check("to_no_done", 5'(dcount), 5'd0);
    repeat (3) cyc();
    check("to_sticky", outv, 5'b10001);
    sw_req = 1; sw_target = 0;
    cyc();
    sw_req = 0;
    check("to_clear_by_same", outv, 5'b10010);

    // New gate opens on the very cycle the RAISE timer hits its limit.
    do_reset();
    sw_req = 1; sw_target = 1; en0_async = 0;
    cyc();
    sw_req = 0;
    cyc();
    cyc();
    repeat (6) cyc();
    en1_async = 1;
    cyc();
    cyc();
    check("edge_pre", outv, 5'b10100);
    cyc();
    check("edge_done", outv, 5'b11010);

    // Request during RAISE is ignored.
    do_reset();
    sw_req = 1; sw_target = 1; en0_async = 0;
    cyc();
    sw_req = 0;
    repeat (3) cyc();
    sw_req = 1; sw_target = 0;
    cyc();
    sw_req = 0; en1_async = 1;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      dcount += int'(done);
    end
    check("busyreq_done_cnt", 5'(dcount), 5'd1);
    check("busyreq_final", outv, 5'b11000);

    // Reset during DROP, with a request held during reset.
    do_reset();
    sw_req = 1; sw_target = 1;
    cyc();
    sw_req = 0;
    cyc();
    rst = 1; sw_req = 1; sw_target = 1;
    cyc();
    check("rst_abort", outv, 5'b00000);
    rst = 0; sw_req = 0;
    cyc();
    check("rst_after", outv, 5'b00000);
    cyc();
    sw_req = 1; sw_target = 1; en0_async = 0;
    cyc();
    sw_req = 0; en1_async = 1;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc();
      if (done) got = 1;
    end
    check("rst_recover_done", {4'b0, got}, 5'd1);
    check("rst_recover_state", outv, 5'b11010);

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      sw_req = ($urandom_range(0, 5) == 0);
      sw_target = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) en0_async = ~en0_async;
      if ($urandom_range(0, 4) == 0) en1_async = ~en1_async;
      cyc();
      check($sformatf("rand_cyc%0d", k), outv, m_outv);
      check($sformatf("rand_excl%0d", k), {4'b0, done & err}, 5'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles allowed per handshake phase (1..65535).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on gated-clock status inputs (>=2).
REQ-003 Parameter INIT_SEL, default 0, clock selected after reset.
REQ-004 clk  input  1  controller clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 sw_req  input  1  switch request; sampled each cycle when high.
REQ-007 sw_target  input  1  requested clock (0 = clk0, 1 = clk1); valid with sw_req.
REQ-008 en0_async  input  1  clk0 gate-enable status from the glitch-free mux, asynchronous to clk.
REQ-009 en1_async  input  1  clk1 gate-enable status from the glitch-free mux, asynchronous to clk.
REQ-010 select  output  1  registered select driven to the glitch-free mux.
REQ-011 cur_sel  output  1  last clock confirmed active.
REQ-012 busy  output  1  switch in progress.
REQ-013 done  output  1  one-cycle pulse on request completion.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 en0_async and en1_async SHALL each pass through a SYNC_STAGES flop chain; only synchronized values (en0_s, en1_s) are used.
REQ-016 FSM states SHALL be STABLE, DROP, RAISE.
REQ-017 STABLE, sw_req=1, sw_target!=cur_sel: next edge select<=sw_target, busy<=1, err<=0, timer<=0, state<=DROP.
REQ-018 STABLE, sw_req=1, sw_target==cur_sel: next edge done pulses 1 cycle, err<=0, select/cur_sel unchanged, state stays STABLE.
REQ-019 DROP: wait until synchronized enable of old clock (index cur_sel) ==0; then timer<=0, state<=RAISE.
REQ-020 RAISE: wait until synchronized enable of new clock (index select) ==1; then cur_sel<=select, busy<=0, done pulses 1 cycle, state<=STABLE.
REQ-021 Timer SHALL increment each cycle in DROP/RAISE, saturating, width ceil(log2(TIMEOUT+1)).
REQ-022 Timer reaching TIMEOUT with exit condition false: err<=1, busy<=0, state<=STABLE, select held at requested value, cur_sel unchanged, no done pulse.
REQ-023 If exit condition and timer==TIMEOUT occur in the same cycle, exit condition SHALL win (normal progress, no err).
REQ-024 sw_req while busy SHALL be ignored, with no queuing and no effect on sw_target capture.
REQ-025 Best-case latency sw_req to done: 1 cycle to select, plus SYNC_STAGES+1 cycles per phase after status change.
REQ-026 done and err SHALL never assert in the same cycle.
REQ-027 select SHALL change only on leaving STABLE (REQ-017) or on reset.

Reset
REQ-028 With rst=1 at a clk edge: select=INIT_SEL, cur_sel=INIT_SEL, busy=0, done=0, err=0, timer=0, synchronizer flops=0, state=STABLE.
REQ-029 Reset mid-switch SHALL abort immediately; select returns to INIT_SEL and no done/err pulse is emitted.
REQ-030 sw_req asserted during reset SHALL be ignored.

Verification
REQ-031 INIT_SEL=0, sw_req with sw_target=1, en0 falls 3 cycles later, en1 rises 4 cycles after that -> select=1 next cycle, busy high, done 1 cycle, cur_sel=1, err=0.
REQ-032 STABLE cur_sel=1, sw_req with sw_target=1 -> done pulse next cycle; select, busy unchanged.
REQ-033 TIMEOUT=8, sw_req target 1, en0 held high -> err=1 and busy=0 at 9th cycle in DROP; cur_sel=0; select=1; no done.
REQ-034 Mid-RAISE second sw_req target 0 -> ignored; switch completes to 1 with single done.
REQ-035 rst pulsed during DROP -> next cycle select=INIT_SEL, busy=0, no done/err; new request then completes normally.
REQ-036 en1 rise exactly when timer==TIMEOUT in RAISE -> done pulses, err stays 0.
